// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, centre-sampled, single-entry valid/ready output
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [7:0]       shift, shift_next;
    logic             rx_meta, rx_s;
    logic             done, done_next;
    logic             ferr_next;
    logic             bit_end;

    assign bit_end = (cnt == BIT_LAST);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            idx       <= idx_next;
            shift     <= shift_next;
            done      <= done_next;
            frame_err <= ferr_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shift_next = shift;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next        = '0;
                    shift_next[idx] = rx_s;
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // a held-low break must produce only the one frame error
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // shift stays untouched while done is high, so it is safe to load here
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : self-checking bench for uart_rx (vector table, directed, random)
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int C     = 434;
    localparam int HALF  = C / 2;
    localparam int LAT   = 2 + HALF + 9 * C + 1;
    localparam int FRAME = 10 * C;

    logic       clk_50M = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #10 clk_50M = ~clk_50M;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_50M  (clk_50M),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_acc;
        logic [7:0] exp_data;
        int         exp_fe;
        logic       chk_lat;
        logic       chk_space;
    } vec_t;

    int         cyc = 0;
    int         tot = 0;
    int         bad = 0;
    int         start_cyc = 0;
    int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, vhi_cnt = 0;
    int         last_rise = -1, prev_rise = -1;
    int         f0, o0, h0;
    logic       v_d = 1'b0;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];
    vec_t       vt[7];

    always @(posedge clk_50M) cyc <= cyc + 1;

    // consumer-side observer: handshakes, pulses and valid rise times
    always @(negedge clk_50M) begin
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (frame_err && overrun) both_cnt++;
        if (rx_valid) vhi_cnt++;
        if (rx_valid && !v_d) begin
            prev_rise = last_rise;
            last_rise = cyc;
        end
        v_d = rx_valid;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (C) tick();
        end
    endtask

    initial begin
        logic       mv;
        logic [7:0] md;
        logic [7:0] d;
        logic       stop, rdy;
        int         efe, eov, gap, lat;

        vt[0] = '{8'h3C, 1'b1, 20, 1, 8'h3C, 0, 1'b0, 1'b0};
        vt[1] = '{8'hA5, 1'b1, 20, 1, 8'hA5, 0, 1'b1, 1'b0};
        vt[2] = '{8'h00, 1'b1,  0, 1, 8'h00, 0, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 1'b1,  0, 1, 8'hFF, 0, 1'b0, 1'b1};
        vt[4] = '{8'h55, 1'b1, 20, 1, 8'h55, 0, 1'b0, 1'b1};
        vt[5] = '{8'h3C, 1'b0, 50, 0, 8'h00, 1, 1'b0, 1'b0};
        vt[6] = '{8'h81, 1'b1, 20, 1, 8'h81, 0, 1'b0, 1'b0};

        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_valid", rx_valid, 0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_ferr", frame_err, 0);
        chk("reset_ovr", overrun, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // short low glitch on an idle line must be rejected
        h0 = vhi_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (100) tick();
        rx = 1'b1;
        repeat (300) tick();
        chk("glitch_valid", vhi_cnt - h0, 0);
        chk("glitch_ferr", fe_cnt - f0, 0);

        rx_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            acc_q.delete();
            f0 = fe_cnt; o0 = ov_cnt; h0 = vhi_cnt;
            send_frame(vt[i].data, vt[i].stop);
            rx = 1'b1;
            repeat (vt[i].gap) tick();
            chk($sformatf("vec%0d_count", i), acc_q.size(), vt[i].exp_acc);
            if (acc_q.size() > 0) chk($sformatf("vec%0d_data", i), acc_q[0], vt[i].exp_data);
            chk($sformatf("vec%0d_ferr", i), fe_cnt - f0, vt[i].exp_fe);
            chk($sformatf("vec%0d_ovr", i), ov_cnt - o0, 0);
            chk($sformatf("vec%0d_valid_cycles", i), vhi_cnt - h0, vt[i].exp_acc);
            if (vt[i].chk_lat) begin
                lat = last_rise - start_cyc;
                tot++;
                if (lat < LAT - 2 || lat > LAT + 2) begin
                    bad++;
                    $display("FAIL vec%0d_latency: got %0d expected %0d+-2", i, lat, LAT);
                end
            end
            if (vt[i].chk_space) chk($sformatf("vec%0d_spacing", i), last_rise - prev_rise, FRAME);
        end

        // overrun: second byte dropped while the first is still held
        rx_ready = 1'b0;
        acc_q.delete();
        o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rx = 1'b1;
        repeat (20) tick();
        chk("ovr_pulse", ov_cnt - o0, 1);
        chk("ovr_valid_held", rx_valid, 1);
        chk("ovr_data_held", rx_data, 8'h11);
        chk("ovr_no_accept", acc_q.size(), 0);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        chk("ovr_accept_clears", rx_valid, 0);
        chk("ovr_accept_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("ovr_accept_data", acc_q[0], 8'h11);

        // accept exactly on the load edge: new byte replaces, no overrun
        acc_q.delete();
        o0 = ov_cnt;
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (LAT) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (20) tick();
        chk("swap_no_ovr", ov_cnt - o0, 0);
        chk("swap_valid", rx_valid, 1);
        chk("swap_data", rx_data, 8'h22);
        chk("swap_accept_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("swap_accept_data", acc_q[0], 8'h11);

        // asynchronous reset in the middle of data bit 4
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (5 * C + C / 2) tick();
                rst_n = 1'b0;
                #1;
                chk("midrst_valid", rx_valid, 0);
                chk("midrst_data", rx_data, 8'h00);
                chk("midrst_ferr", frame_err, 0);
                chk("midrst_ovr", overrun, 0);
            end
        join
        rx = 1'b1;
        repeat (10) tick();
        f0 = fe_cnt; o0 = ov_cnt; h0 = vhi_cnt;
        acc_q.delete();
        rst_n = 1'b1;
        repeat (50) tick();
        chk("postrst_quiet", (vhi_cnt - h0) + (fe_cnt - f0) + (ov_cnt - o0), 0);
        rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        repeat (20) tick();
        chk("postrst_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("postrst_data", acc_q[0], 8'hC3);
        chk("postrst_ferr", fe_cnt - f0, 0);

        // random frames against a holding-register reference model
        mv = 1'b0;
        md = 8'h00;
        for (int r = 0; r < 3; r++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            rdy  = 1'($urandom_range(0, 1));
            gap  = stop ? int'($urandom_range(0, 30)) : int'($urandom_range(5, 50));
            efe  = 0;
            eov  = 0;
            exp_q.delete();
            acc_q.delete();
            f0 = fe_cnt; o0 = ov_cnt;
            rx_ready = rdy;
            if (rdy && mv) begin
                exp_q.push_back(md);
                mv = 1'b0;
            end
            if (!stop) efe = 1;
            else if (!mv) begin
                if (rdy) exp_q.push_back(d);
                else begin
                    mv = 1'b1;
                    md = d;
                end
            end else eov = 1;
            send_frame(d, stop);
            rx = 1'b1;
            repeat (gap) tick();
            chk($sformatf("rnd%0d_count", r), acc_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
                chk($sformatf("rnd%0d_data%0d", r, k), acc_q[k], exp_q[k]);
            chk($sformatf("rnd%0d_ferr", r), fe_cnt - f0, efe);
            chk($sformatf("rnd%0d_ovr", r), ov_cnt - o0, eov);
            chk($sformatf("rnd%0d_valid", r), rx_valid, mv);
            if (mv) chk($sformatf("rnd%0d_held", r), rx_data, md);
        end

        chk("flags_exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; receive-side counterpart of the team's 8N1 transmitter on the 50 MHz clock domain.
- Oversamples the asynchronous `rx` line, centre-samples 1 start, 8 data (LSB first) and 1 stop bit.
- Presents each good byte through a single-entry valid/ready holding register.
- Flags framing errors and overruns as one-cycle pulses for the downstream consumer (status/FIFO logic).

Parameters:
- CLKS_PER_BIT, 434, clk_50M cycles per bit (50 MHz / 434 ≈ 115200 baud; matches transmitter bit period). Must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (217), cycles from detected start edge to the start-bit centre sample.

Ports:
- clk_50M  in  1  system clock, 50 MHz, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, asynchronous to clk_50M, idle high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  holding register full; held until accepted.
- rx_ready  in  1  consumer accepts byte when rx_valid&&rx_ready on a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte completed while holding register full and not being accepted.

Behaviour:
- Clocking and reset:
  - Single clock; reset is asynchronous, active-low (rst_n).
  - On reset: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, state=IDLE, counters/shift register cleared, synchronizer flops=1.
- Input sync: `rx` passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- State machine, bit counter 0..CLKS_PER_BIT-1, bit index 0..7:
  - IDLE: counter=0. rx_s==0 → START.
  - START: count to HALF_BIT-1 and sample there.
    - rx_s==0 → DATA, counter=0, index=0.
    - rx_s==1 → IDLE (glitch rejected, no flags).
  - DATA: at counter==CLKS_PER_BIT-1, shift rx_s into bit[index] (LSB first) and set counter=0.
    - index==7 → STOP; else index+1.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s.
    - 1 → deliver byte, go IDLE (resync inside stop bit allowed).
    - 0 → frame_err pulse, byte discarded, → WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. A held-low break generates exactly one frame_err.
- Delivery, on the cycle after the stop sample:
  - If rx_valid==0, or rx_valid&&rx_ready in the same cycle: load rx_data, rx_valid=1.
  - Else: overrun pulse; old rx_data and rx_valid kept; new byte dropped.
- Handshake: rx_valid clears on the edge where rx_valid&&rx_ready, unless a new byte loads that same edge. In that case rx_valid stays 1 with the new data.
- rx_ready while rx_valid=0 has no effect.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the rx pin falling edge, nominally 4126 at default, bench tolerance ±2.
- frame_err and overrun are never both asserted in the same cycle.
- Reset mid-frame: immediate return to IDLE, partial byte lost, no flags after release. The next falling edge starts a fresh frame.
- Counter width: $clog2(CLKS_PER_BIT); comparisons must not wrap.

Test Plan:
- Send 8'hA5 at 434 clk/bit, rx_ready=1 → rx_valid pulses 1 cycle ~4126 cycles after start edge, rx_data=8'hA5, no flags.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap, rx_ready=1 → three valids with correct data, spacing 4340 cycles, no flags.
- 100-cycle low glitch on idle rx → no rx_valid, no frame_err, FSM back in IDLE; a following 8'h3C is received correctly.
- Frame 8'h3C with stop bit driven 0, then line high → frame_err single pulse, no rx_valid; next frame 8'h81 received OK.
- rx_ready=0; send 8'h11 then 8'h22 → rx_data=8'h11 held, rx_valid=1, overrun pulse at second stop.
  - Then rx_ready=1 for one cycle → rx_valid=0.
  - Repeat with rx_ready asserted exactly on the load cycle → rx_data=8'h22, no overrun.
- Assert rst_n=0 mid-data-bit 4 of a frame → all outputs at reset values immediately; after release a clean 8'hC3 frame is received correctly.
